// File: rtl/dtw_band_cell.sv
// Banded (Sakoe-Chiba) DTW cost engine feeding an external shift_register_dtw.
// Optional early abandon on a per-row threshold: define DTW_EARLY_ABANDON_EN.
module dtw_band_cell #(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned SAMPLE_W = 16,
    parameter int unsigned R        = 9,
    parameter int unsigned N        = 64
) (
    input  logic                   clk,
    input  logic                   rst,
`ifdef DTW_EARLY_ABANDON_EN
    input  logic [WIDTH-1:0]       threshold,
    output logic                   abandoned,
`endif
    input  logic                   start,
    input  logic [$clog2(N+1)-1:0] len,
    output logic [$clog2(N)-1:0]   q_addr,
    input  logic [SAMPLE_W-1:0]    q_data,
    output logic [$clog2(N)-1:0]   r_addr,
    input  logic [SAMPLE_W-1:0]    r_data,
    input  logic [WIDTH-1:0]       last,
    input  logic [WIDTH-1:0]       band,
    input  logic [WIDTH-1:0]       out,
    output logic [WIDTH-1:0]       cost,
    output logic                   ready,
    output logic                   busy,
    output logic                   done,
    output logic [WIDTH-1:0]       result
);
    localparam int unsigned AW = $clog2(N);
    localparam int unsigned LW = $clog2(N+1);
    localparam int unsigned H  = (R - 1) / 2;
    localparam int unsigned KW = (R > 1) ? $clog2(R) : 1;
    localparam int unsigned JW = LW + KW + 1;
    localparam logic [WIDTH-1:0] INF = {4'b0000, {(WIDTH-4){1'b1}}};

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

    // Per-cell flags travelling down the pipeline beside the RAM read.
    typedef struct packed {
        logic          v;
        logic          inr;
        logic          org;
        logic          row0;
        logic          cap;
        logic [KW-1:0] k;
    } cell_t;

    state_e state_q, state_d;

    logic [LW-1:0]    len_q, len_d, len_eff_c, cur_len_c;
    logic [AW-1:0]    i_q, i_d, cur_i_c;
    logic [KW-1:0]    k_q, k_d, cur_k_c;
    logic [JW-1:0]    cur_j_c;
    logic             cur_inr_c, last_cell_c, issue_c, start_acc_c;
    logic             drain_q, drain_d;
    logic [AW-1:0]    q_addr_q, q_addr_d, r_addr_q, r_addr_d;
    cell_t            st0_q, st0_d, st1_q, st1_d, st2_q, st2_d;
    logic [WIDTH-1:0] d2_q, d2_d;
    logic             busy_q, busy_d, done_q, done_d;
    logic [WIDTH-1:0] res_cap_q, res_cap_d, result_q, result_d;
    logic [WIDTH-1:0] left_c, up_c, diag_c, m_c, cost_c;
    logic [WIDTH:0]   sum_c;
    logic             abandon_c, aband_any_c;

    assign start_acc_c = (state_q == IDLE) && start;

    // Combine |q-r| with the forced minimum of the three shift-register taps.
    always_comb begin
        left_c = (st2_q.k == '0) ? INF : last;
        up_c   = ((st2_q.k == KW'(R-1)) || st2_q.row0) ? INF : band;
        diag_c = st2_q.row0 ? INF : out;
        m_c    = left_c;
        if (up_c < m_c)   m_c = up_c;
        if (diag_c < m_c) m_c = diag_c;
        if (st2_q.org)    m_c = '0;
        sum_c  = {1'b0, d2_q} + {1'b0, m_c};
        cost_c = INF;
        if (st2_q.v && st2_q.inr && (m_c != INF))
            cost_c = (sum_c > {1'b0, INF}) ? INF : sum_c[WIDTH-1:0];
    end

    assign cost = cost_c;

`ifdef DTW_EARLY_ABANDON_EN
    logic [WIDTH-1:0] thr_q;
    logic             row_ok_q, aband_q, abandoned_q, hit_c;

    assign hit_c       = st2_q.v && st2_q.inr && (cost_c < thr_q);
    assign abandon_c   = st2_q.v && (st2_q.k == KW'(R-1)) && !(row_ok_q || hit_c);
    assign aband_any_c = aband_q || abandon_c;
    assign abandoned   = abandoned_q;

    // Row-level "anything below threshold" tracker; cleared at each row end.
    always_ff @(posedge clk) begin
        if (rst) begin
            thr_q       <= '0;
            row_ok_q    <= 1'b0;
            aband_q     <= 1'b0;
            abandoned_q <= 1'b0;
        end else if (start_acc_c) begin
            thr_q       <= threshold;
            row_ok_q    <= 1'b0;
            aband_q     <= 1'b0;
            abandoned_q <= 1'b0;
        end else begin
            if (st2_q.v)
                row_ok_q <= (st2_q.k == KW'(R-1)) ? 1'b0 : (row_ok_q || hit_c);
            if (abandon_c)
                aband_q <= 1'b1;
            if (state_q == DONE)
                abandoned_q <= aband_any_c;
        end
    end
`else
    assign abandon_c   = 1'b0;
    assign aband_any_c = 1'b0;
`endif

    // Cell being issued this cycle and its band geometry.
    always_comb begin
        len_eff_c   = (len > LW'(N)) ? LW'(N) : len;
        cur_len_c   = (state_q == IDLE) ? len_eff_c : len_q;
        cur_i_c     = (state_q == IDLE) ? '0 : i_q;
        cur_k_c     = (state_q == IDLE) ? '0 : k_q;
        cur_j_c     = JW'(cur_i_c) + JW'(cur_k_c) - JW'(H);
        cur_inr_c   = !cur_j_c[JW-1] && (cur_j_c < JW'(cur_len_c));
        last_cell_c = (LW'(cur_i_c) == cur_len_c - LW'(1)) && (cur_k_c == KW'(R-1));
        issue_c     = (start_acc_c && (len_eff_c != '0)) || ((state_q == RUN) && !abandon_c);
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = (len_eff_c == '0) ? DONE : (last_cell_c ? DRAIN : RUN);
            RUN:     if (abandon_c || last_cell_c) state_d = DRAIN;
            DRAIN:   if (drain_q) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        i_d       = i_q;
        k_d       = k_q;
        len_d     = len_q;
        q_addr_d  = q_addr_q;
        r_addr_d  = r_addr_q;
        st0_d     = '0;
        st1_d     = abandon_c ? '0 : st0_q;
        st2_d     = abandon_c ? '0 : st1_q;
        d2_d      = WIDTH'((q_data >= r_data) ? (q_data - r_data) : (r_data - q_data));
        drain_d   = (state_q == DRAIN) && !drain_q;
        busy_d    = (state_d != IDLE);
        done_d    = (state_q == DONE);
        res_cap_d = res_cap_q;
        result_d  = result_q;
        if (start_acc_c) begin
            len_d     = len_eff_c;
            res_cap_d = INF;
        end
        if (issue_c) begin
            q_addr_d   = cur_i_c;
            r_addr_d   = cur_inr_c ? AW'(cur_j_c) : '0;
            st0_d.v    = 1'b1;
            st0_d.inr  = cur_inr_c;
            st0_d.org  = (cur_i_c == '0) && (cur_j_c == '0);
            st0_d.row0 = (cur_i_c == '0);
            st0_d.cap  = (LW'(cur_i_c) == cur_len_c - LW'(1)) && (cur_k_c == KW'(H));
            st0_d.k    = cur_k_c;
            if (cur_k_c == KW'(R-1)) begin
                i_d = cur_i_c + AW'(1);
                k_d = '0;
            end else begin
                i_d = cur_i_c;
                k_d = cur_k_c + KW'(1);
            end
        end
        if (st2_q.v && st2_q.cap) res_cap_d = cost_c;
        if (state_q == DONE) result_d = aband_any_c ? INF : res_cap_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            i_q       <= '0;
            k_q       <= '0;
            len_q     <= '0;
            q_addr_q  <= '0;
            r_addr_q  <= '0;
            st0_q     <= '0;
            st1_q     <= '0;
            st2_q     <= '0;
            d2_q      <= '0;
            drain_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            res_cap_q <= INF;
            result_q  <= INF;
        end else begin
            i_q       <= i_d;
            k_q       <= k_d;
            len_q     <= len_d;
            q_addr_q  <= q_addr_d;
            r_addr_q  <= r_addr_d;
            st0_q     <= st0_d;
            st1_q     <= st1_d;
            st2_q     <= st2_d;
            d2_q      <= d2_d;
            drain_q   <= drain_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            res_cap_q <= res_cap_d;
            result_q  <= result_d;
        end
    end

    assign q_addr = q_addr_q;
    assign r_addr = r_addr_q;
    assign ready  = st2_q.v;
    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;

endmodule

// File: doc/dtw_band_cell.md
# dtw_band_cell

Banded dynamic-time-warping cost engine that drives `shift_register_dtw`. It walks a Sakoe-Chiba band of R cells per row in raster order and reads query and reference samples from two external single-port RAMs. For each cell it combines `|q-r|` with the minimum of the left, up and diagonal neighbours held in the shift register, then pushes the new cost back with a `ready` pulse. It reports the final alignment cost of cell (L-1,L-1).

## Interface

Parameters:

- `WIDTH`, 32: cost width; must match the shift register.
- `SAMPLE_W`, 16: sample width, unsigned.
- `R`, 9: band width in cells per row; must be odd and must match the shift register. Half-width H = (R-1)/2.
- `N`, 64: maximum sequence length. AW = $clog2(N), LW = $clog2(N+1).

Ports:

- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: launch request; sampled only in IDLE.
- `len` in LW: sequence length L, latched at start. A value above N is clamped to N.
- `q_addr` out AW, `q_data` in SAMPLE_W: query RAM port, 1-cycle read latency.
- `r_addr` out AW, `r_data` in SAMPLE_W: reference RAM port, 1-cycle read latency.
- `last` in WIDTH: left neighbour, sreg[0].
- `band` in WIDTH: up neighbour, sreg[R-2].
- `out` in WIDTH: diagonal neighbour, sreg[R-1].
- `cost` out WIDTH: new cell cost, drives the shift register `in`.
- `ready` out 1: shift enable, one pulse per cell.
- `busy` out 1: run in progress.
- `done` out 1: one-cycle completion pulse.
- `result` out WIDTH: final cost, held until the next start.

## Operation

- INF = {4'b0000, ones}; 0x0FFFFFFF when WIDTH=32.
- Cell n maps to row i = n / R and band slot k = n % R. Column j = i - H + k. There are L*R cells in total.
- FSM states:
  - IDLE: `start` with L≥1 moves to RUN. `start` with L=0 moves to DONE with `result`=INF.
  - RUN: issues one cell per cycle. After cell L*R-1 is issued, moves to DRAIN.
  - DRAIN: waits 2 cycles, then moves to DONE.
  - DONE: `done`=1 for one cycle, then back to IDLE.
- Pipeline stages:
  - S0 issue: `q_addr`=i. `r_addr`=j when 0≤j<L, else 0. Also registers the in-range flag, k, and the origin/row-0 flags.
  - S1: d = |q_data - r_data|, zero-extended to WIDTH and registered.
  - S2: `ready`=1 and `cost` is combinational from registered d and the live taps.
- Neighbour forcing rules:
  - left = INF when k=0.
  - up = INF when k=R-1 or i=0.
  - diag = INF when i=0.
  - m = min(left, up, diag), except m = 0 for cell (0,0).
- Cost rules:
  - Out-of-range cell (j<0 or j≥L): `cost` = INF.
  - In range: `cost` = INF if m=INF, else min(d+m, INF), computed with a WIDTH+1 sum.
- `result` captures `cost` at i=L-1, k=H.
- `start` during RUN, DRAIN or DONE is ignored.
- Stale shift-register contents from a previous run are harmless because of the i=0 forcing. No flush is needed.

## Timing

- If `start` is sampled in IDLE at cycle t:
  - cell n is issued at t+1+n;
  - cell n has `ready` high at t+3+n;
  - `busy` is high from t+1 to t+2+L*R;
  - `done` and the updated `result` appear at t+3+L*R.
- Throughput is one cell per cycle. The left value for cell n+1 is the shift register's registered copy of cell n.
- `ready` pulses exactly L*R times per run, never back-pressured.
- Reset values: FSM=IDLE, `ready`=0, `done`=0, `busy`=0, `result`=INF, `cost`=INF, `q_addr`=0, `r_addr`=0.
- Reset mid-run aborts immediately. No further `ready` pulses occur and `done` is not asserted.
- A new `start` is accepted in the cycle after `done`.

## Configuration

- `DTW_EARLY_ABANDON_EN` defined:
  - Adds input `threshold` (WIDTH) and output `abandoned` (1). `threshold` is latched at start; `abandoned` resets to 0.
  - Per row, the block tracks whether any in-range cost is below `threshold`.
  - At the end of a row with no such cost, RUN stops issuing cells and moves to DRAIN, then DONE. At DONE, `result`=INF and `abandoned`=1.
  - `abandoned` clears on the next start.
- `DTW_EARLY_ABANDON_EN` undefined: neither port exists, and every run processes all L*R cells.

## Test plan

- L=1, q[0]=5, r[0]=2, R=9, start at t: `done` at t+12, `result`=3, exactly 9 `ready` pulses, 8 of them with `cost`=0x0FFFFFFF.
- L=8, identical sequences q=r=10,20,…,80: `result`=0, `done` at t+3+72.
- L=8, q[i]=i, r[i]=i+1: `result`=2 (warped path).
- L=0: `done` at t+2, `result`=INF, no `ready` pulses. A second start one cycle after `done` runs normally.
- Assert `rst` at t+20 during an L=8 run: the next cycle shows `ready`=0, `busy`=0, `result`=INF, and no `done` ever appears. A following start succeeds with a correct result.
- `DTW_EARLY_ABANDON_EN`, `threshold`=10, q=0, r=1000, L=8: `abandoned`=1, `result`=INF, exactly 9 `ready` pulses (row 0 only), and `done` shortly after row 0 drains.
